// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response handshake and data-memory bus
// seen from the access controller (master) and its environment (slave).
interface mem_access_ctrl_if #(
  parameter int DATA_WID = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [DATA_WID-1:0] req_addr;
  logic [DATA_WID-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_WID-1:0] resp_data;
  logic                resp_error;
  logic [DATA_WID-1:0] mem_addr;
  logic [DATA_WID-1:0] mem_write_data;
  logic                mem_write_flag;
  logic                mem_read_flag;
  logic [DATA_WID-1:0] mem_valM;
  logic                mem_error;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  resp_ready, mem_valM, mem_error,
    output req_ready, resp_valid, resp_data, resp_error,
    output mem_addr, mem_write_data,
    output mem_write_flag, mem_read_flag
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output resp_ready, mem_valM, mem_error,
    input  req_ready, resp_valid, resp_data, resp_error,
    input  mem_addr, mem_write_data,
    input  mem_write_flag, mem_read_flag
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: one load/store at a time,
// range trap before the memory, sticky address-error status.
module mem_access_ctrl #(
  parameter int DATA_WID    = 32,
  parameter int MAX_ADDR    = 10,
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_ctrl_if.master bus,
  output logic stat_adr,
  output logic busy
);

  localparam int CW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(MEM_LATENCY - 1);
  localparam logic [DATA_WID-1:0] MAX_A =
    DATA_WID'(MAX_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_WID-1:0] addr_q, addr_d;
  logic [DATA_WID-1:0] wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_WID-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                stat_q, stat_d;
  logic                accept;
  logic                in_access;

  assign in_access = (state_q == ACCESS);
  assign accept = bus.req_valid && bus.req_ready;

  assign bus.req_ready      = (state_q == IDLE) && !stat_q;
  assign bus.resp_valid     = (state_q == RESP);
  assign bus.resp_data      = rdata_q;
  assign bus.resp_error     = err_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_write_flag = in_access && write_q;
  assign bus.mem_read_flag  = in_access && !write_q;
  assign stat_adr           = stat_q;
  assign busy               = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stat_d  = stat_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          rdata_d = '0;
          // Trap out-of-range before any flag is raised
          if (bus.req_addr > MAX_A) begin
            state_d = RESP;
            err_d   = 1'b1;
            stat_d  = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_INIT;
            err_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          err_d   = bus.mem_error;
          stat_d  = stat_q || bus.mem_error;
          if (write_q || bus.mem_error) rdata_d = '0;
          else                          rdata_d = bus.mem_valM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stat_q  <= stat_d;
    end
  end

endmodule
